// File: rtl/cmp_result_monitor.sv
// Comparator result monitor: per-kind saturating counters, run/streak tracking, sticky error.
// Optional strict one-hot checking of the flag vector is enabled by defining CMP_MON_ONEHOT_CHECK_EN.
module cmp_result_monitor #(
  parameter int unsigned STREAK_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       gt,
  input  logic       eq,
  input  logic       l,
  input  logic       clr,
  output logic [7:0] gt_cnt,
  output logic [7:0] eq_cnt,
  output logic [7:0] lt_cnt,
  output logic       streak,
  output logic [1:0] streak_kind,
  output logic       err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned RUN_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(255);
  localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(15);
  localparam logic [RUN_W-1:0] STREAK_TGT = RUN_W'(STREAK_LEN);

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_EQ   = 2'b01;
  localparam logic [1:0] KIND_GT   = 2'b10;
  localparam logic [1:0] KIND_LT   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic [1:0]       kind_q, kind_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;
  logic             streak_q, streak_d;
  logic             err_q, err_d;

  logic             accept_c;
  logic             illegal_c;
  logic [1:0]       sample_kind_c;

  // Acceptance and illegal-vector qualification of the incoming flags
`ifdef CMP_MON_ONEHOT_CHECK_EN
  logic onehot_c;
  assign onehot_c  = ({gt, eq, l} == 3'b100) || ({gt, eq, l} == 3'b010) ||
                     ({gt, eq, l} == 3'b001);
  assign accept_c  = in_valid && onehot_c;
  assign illegal_c = in_valid && !onehot_c;
`else
  assign accept_c  = in_valid && (gt || eq || l);
  assign illegal_c = 1'b0;
`endif

  // Priority decode gt > eq > l; only matters for multi-hot vectors
  assign sample_kind_c = gt ? KIND_GT : (eq ? KIND_EQ : KIND_LT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    kind_d    = kind_q;
    gt_cnt_d  = gt_cnt_q;
    eq_cnt_d  = eq_cnt_q;
    lt_cnt_d  = lt_cnt_q;
    streak_d  = 1'b0;
    err_d     = err_q;

    if (clr) begin
      state_d   = IDLE;
      run_len_d = '0;
      kind_d    = KIND_NONE;
      gt_cnt_d  = '0;
      eq_cnt_d  = '0;
      lt_cnt_d  = '0;
      err_d     = 1'b0;
    end else if (illegal_c) begin
      state_d   = IDLE;
      run_len_d = '0;
      kind_d    = KIND_NONE;
      err_d     = 1'b1;
    end else if (accept_c) begin
      unique case (sample_kind_c)
        KIND_GT: gt_cnt_d = sat_inc(gt_cnt_q);
        KIND_EQ: eq_cnt_d = sat_inc(eq_cnt_q);
        default: lt_cnt_d = sat_inc(lt_cnt_q);
      endcase

      unique case (state_q)
        IDLE: begin
          state_d   = RUN;
          run_len_d = RUN_W'(1);
          kind_d    = sample_kind_c;
        end
        RUN: begin
          if (kind_q == sample_kind_c) begin
            // Saturating length means the target is crossed at most once per run
            if (run_len_q != RUN_MAX) begin
              run_len_d = run_len_q + RUN_W'(1);
              streak_d  = (run_len_q + RUN_W'(1)) == STREAK_TGT;
            end
          end else begin
            run_len_d = RUN_W'(1);
            kind_d    = sample_kind_c;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      run_len_q <= '0;
      kind_q    <= KIND_NONE;
      gt_cnt_q  <= '0;
      eq_cnt_q  <= '0;
      lt_cnt_q  <= '0;
      streak_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      kind_q    <= kind_d;
      gt_cnt_q  <= gt_cnt_d;
      eq_cnt_q  <= eq_cnt_d;
      lt_cnt_q  <= lt_cnt_d;
      streak_q  <= streak_d;
      err_q     <= err_d;
    end
  end

  assign gt_cnt      = gt_cnt_q;
  assign eq_cnt      = eq_cnt_q;
  assign lt_cnt      = lt_cnt_q;
  assign streak      = streak_q;
  assign streak_kind = kind_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Bench for cmp_result_monitor: directed scenarios plus random traffic against a behavioural model.
// Follows CMP_MON_ONEHOT_CHECK_EN the same way the design does.
module tb_cmp_result_monitor;

  localparam int unsigned STREAK_LEN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, gt, eq, l, clr;
  logic [7:0] gt_cnt, eq_cnt, lt_cnt;
  logic       streak;
  logic [1:0] streak_kind;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: counts indexed by kind code (1 eq, 2 gt, 3 lt)
  int         m_cnt [1:3];
  int         m_run_len;
  logic [1:0] m_kind;
  logic       m_streak;
  logic       m_err;
  int         streak_seen;
  logic [2:0] last_vec;

  cmp_result_monitor #(.STREAK_LEN(STREAK_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .gt(gt), .eq(eq), .l(l), .clr(clr),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
    .streak(streak), .streak_kind(streak_kind), .err(err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int k = 1; k <= 3; k++) m_cnt[k] = 0;
    m_run_len = 0;
    m_kind    = 2'b00;
    m_streak  = 1'b0;
    m_err     = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic g, input logic e,
                                     input logic ll, input logic c);
    int ones, k, prev;
    ones     = int'(g) + int'(e) + int'(ll);
    m_streak = 1'b0;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) return;
`ifdef CMP_MON_ONEHOT_CHECK_EN
    if (ones != 1) begin
      m_err     = 1'b1;
      m_run_len = 0;
      m_kind    = 2'b00;
      return;
    end
`else
    if (ones == 0) return;
`endif
    k = g ? 2 : (e ? 1 : 3);
    if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
    if (m_run_len > 0 && int'(m_kind) == k) begin
      prev = m_run_len;
      if (m_run_len < 15) m_run_len = m_run_len + 1;
      m_streak = (m_run_len == STREAK_LEN) && (prev != STREAK_LEN);
    end else begin
      m_run_len = 1;
      m_kind    = 2'(k);
    end
  endfunction

  task automatic check_all(input string tag);
    logic [27:0] obs, exp;
    obs = {gt_cnt, eq_cnt, lt_cnt, streak, streak_kind, err};
    exp = {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[3]), m_streak, m_kind, m_err};
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed gt/eq/lt/stk/kind/err=%h required %h", tag, obs, exp);
      end
    if (streak === 1'b1) streak_seen++;
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
  endtask

  // One clock: drive on the falling edge, compare 1 time unit after the rising edge
  task automatic step(input string tag, input logic v, input logic g, input logic e,
                      input logic ll, input logic c);
    @(negedge clk);
    in_valid = v; gt = g; eq = e; l = ll; clr = c;
    @(posedge clk);
    #1;
    model_step(v, g, e, ll, c);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; gt = 1'b0; eq = 1'b0; l = 1'b0; clr = 1'b0;
    model_reset();
    streak_seen = 0;
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Three eq samples: streak visible right after the third edge, then drops
    for (int i = 0; i < 3; i++) step("eq_run", 1, 0, 1, 0, 0);
    chk_int("eq3_streak", int'(streak), 1);
    chk_int("eq3_cnt", int'(eq_cnt), 3);
    chk_int("eq3_kind", int'(streak_kind), 1);
    step("eq_idle", 0, 0, 0, 0, 0);
    chk_int("eq3_streak_drop", int'(streak), 0);

    // 300 gt samples saturate at 255, one streak pulse only
    step("clr1", 0, 0, 0, 0, 1);
    streak_seen = 0;
    for (int i = 0; i < 300; i++) step("gt_sat", 1, 1, 0, 0, 0);
    chk_int("gt_sat_cnt", int'(gt_cnt), 255);
    chk_int("gt_sat_pulses", streak_seen, 1);

    // gt,gt,l,l,l with idle gaps between the l samples
    step("clr2", 0, 0, 0, 0, 1);
    streak_seen = 0;
    step("seq_gt", 1, 1, 0, 0, 0);
    step("seq_gt", 1, 1, 0, 0, 0);
    step("seq_l", 1, 0, 0, 1, 0);
    step("seq_idle", 0, 0, 0, 0, 0);
    step("seq_l", 1, 0, 0, 1, 0);
    step("seq_idle", 0, 0, 0, 0, 0);
    step("seq_idle", 0, 0, 0, 0, 0);
    step("seq_l", 1, 0, 0, 1, 0);
    chk_int("seq_streak_now", int'(streak), 1);
    chk_int("seq_kind", int'(streak_kind), 3);
    step("seq_idle", 0, 0, 0, 0, 0);
    chk_int("seq_gt_cnt", int'(gt_cnt), 2);
    chk_int("seq_lt_cnt", int'(lt_cnt), 3);
    chk_int("seq_pulses", streak_seen, 1);

    // Multi-hot gt+eq vector
    step("clr3", 0, 0, 0, 0, 1);
    step("mh_gt", 1, 0, 0, 1, 0);
    step("mh_vec", 1, 1, 1, 0, 0);
    step("mh_idle", 0, 0, 0, 0, 0);
`ifdef CMP_MON_ONEHOT_CHECK_EN
    chk_int("mh_err", int'(err), 1);
    chk_int("mh_kind", int'(streak_kind), 0);
    chk_int("mh_gt_cnt", int'(gt_cnt), 0);
    step("mh_after", 1, 0, 1, 0, 0);
    chk_int("mh_err_sticky", int'(err), 1);
`else
    chk_int("mh_err", int'(err), 0);
    chk_int("mh_gt_cnt", int'(gt_cnt), 1);
    step("zero_vec", 1, 0, 0, 0, 0);
    chk_int("zero_vec_lt", int'(lt_cnt), 1);
`endif

    // Counts 5/5/5 then clr with a simultaneous eq sample
    step("clr4", 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("five_gt", 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("five_eq", 1, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("five_lt", 1, 0, 0, 1, 0);
    step("clr_eq", 1, 0, 1, 0, 1);
    chk_int("clr_eq_cnt", int'(eq_cnt), 0);
    chk_int("clr_kind", int'(streak_kind), 0);
    chk_int("clr_err", int'(err), 0);

    // Asynchronous reset between edges in the middle of an eq run
    step("pre_rst_eq", 1, 0, 1, 0, 0);
    step("pre_rst_eq", 1, 0, 1, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;
    streak_seen = 0;
    step("post_rst_eq", 1, 0, 1, 0, 0);
    step("post_rst_eq", 1, 0, 1, 0, 0);
    step("post_rst_idle", 0, 0, 0, 0, 0);
    chk_int("post_rst_no_streak", streak_seen, 0);
    chk_int("post_rst_eq_cnt", int'(eq_cnt), 2);

    // Random traffic, biased toward repeating kinds so streaks occur
    last_vec = 3'b010;
    for (int i = 0; i < 800; i++) begin
      logic [2:0] vec;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 8)       vec = 3'($urandom_range(0, 7));
      else if (r < 65) vec = last_vec;
      else begin
        case ($urandom_range(0, 2))
          0:       vec = 3'b100;
          1:       vec = 3'b010;
          default: vec = 3'b001;
        endcase
      end
      last_vec = vec;
      step("random", 1'($urandom_range(0, 3) != 0), vec[2], vec[1], vec[0],
           1'($urandom_range(0, 59) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
